// File: rtl/capture_sprite_bg.sv
// capture_sprite_bg: copies a Width x Height screen region from the framebuffer
// read port into sprite/background memory, one pixel at a time, row-major.
// Pixels outside the visible screen are stored as the transparency colour.
module capture_sprite_bg #(
    parameter int         READ_LATENCY = 1,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [8:0] TRANSP       = 9'b100101110
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    input  logic [7:0]  Xin,
    input  logic [6:0]  Yin,
    input  logic [4:0]  Width,
    input  logic [4:0]  Height,
    input  logic [2:0]  Slot,
    input  logic [2:0]  Sel,
    input  logic [8:0]  FbData,
    output logic        FbRead,
    output logic [7:0]  Xout,
    output logic [6:0]  Yout,
    output logic [2:0]  MemSel,
    output logic [11:0] Address,
    output logic [8:0]  DataOut,
    output logic        WriteEn,
    output logic        Done
);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_xs;
    logic [6:0]  r_ys;
    logic [4:0]  r_ws;
    logic [4:0]  r_hs;
    logic [2:0]  r_ss;
    logic [4:0]  r_xoff;
    logic [4:0]  r_yoff;
    logic [1:0]  r_cnt;
    logic [8:0]  r_dout;

    logic [8:0]  w_xsum;
    logic [7:0]  w_ysum;
    logic        w_clip;
    logic        w_xlast;
    logic        w_ylast;
    logic        w_empty;
    logic        w_last_wait;

    // Unwrapped sums decide clipping; the wrapped low bits drive the read address.
    assign w_xsum      = {1'b0, r_xs} + {4'b0000, r_xoff};
    assign w_ysum      = {1'b0, r_ys} + {3'b000, r_yoff};
    assign w_clip      = (w_xsum >= 9'(SCREEN_W)) | (w_ysum >= 8'(SCREEN_H));
    assign w_xlast     = (r_xoff == (r_ws - 5'd1));
    assign w_ylast     = (r_yoff == (r_hs - 5'd1));
    assign w_empty     = (Width == 5'd0) | (Height == 5'd0);
    assign w_last_wait = (r_cnt == 2'd1);

    assign Xout    = w_xsum[7:0];
    assign Yout    = w_ysum[6:0];
    assign MemSel  = Sel;
    assign DataOut = r_dout;
    // Block base is Ss*Ws*Hs; all terms are taken modulo 4096.
    assign Address = 12'(r_xoff) + 12'(r_yoff) * 12'(r_ws)
                   + 12'(r_ss) * 12'(r_ws) * 12'(r_hs);

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_START;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: each pixel is ISSUE, READ_LATENCY WAIT cycles, WRITE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START: w_next = S_IDLE;
            S_IDLE:  if (Enable && !w_empty) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_last_wait) w_next = S_WRITE;
            S_WRITE: w_next = (w_xlast && w_ylast) ? S_IDLE : S_ISSUE;
            default: w_next = S_START;
        endcase
    end

    // Output decode; purely from state so reset drops strobes immediately.
    always_comb begin
        FbRead  = 1'b0;
        WriteEn = 1'b0;
        Done    = 1'b0;
        case (r_state)
            S_IDLE:  Done    = 1'b1;
            S_ISSUE: FbRead  = ~w_clip;
            S_WRITE: WriteEn = 1'b1;
            default: ;
        endcase
    end

    // Region latch, offset walk, latency counter and captured pixel.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_xs   <= '0;
            r_ys   <= '0;
            r_ws   <= '0;
            r_hs   <= '0;
            r_ss   <= '0;
            r_xoff <= '0;
            r_yoff <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Enable) begin
                        r_xs   <= Xin;
                        r_ys   <= Yin;
                        r_ws   <= Width;
                        r_hs   <= Height;
                        r_ss   <= Slot;
                        r_xoff <= '0;
                        r_yoff <= '0;
                    end
                end
                S_ISSUE: r_cnt <= 2'(READ_LATENCY);
                S_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (w_last_wait) begin
                        r_dout <= w_clip ? TRANSP : FbData;
                    end
                end
                S_WRITE: begin
                    if (!w_xlast) begin
                        r_xoff <= r_xoff + 5'd1;
                    end else if (!w_ylast) begin
                        r_xoff <= '0;
                        r_yoff <= r_yoff + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_sprite_bg.sv
// Directed testbench for capture_sprite_bg: one latency-1 and one latency-3
// instance share the region inputs, each with its own framebuffer model.
module tb_capture_sprite_bg;

    localparam logic [8:0] TRANSP  = 9'b100101110;
    localparam logic [8:0] GARBAGE = 9'h0AA;

    logic        clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        en1 = 1'b0;
    logic        en3 = 1'b0;
    logic [7:0]  Xin = '0;
    logic [6:0]  Yin = '0;
    logic [4:0]  Width = '0;
    logic [4:0]  Height = '0;
    logic [2:0]  Slot = '0;
    logic [2:0]  Sel = '0;

    logic [8:0]  FbData1, FbData3, DataOut1, DataOut3;
    logic        FbRead1, FbRead3, WriteEn1, WriteEn3, Done1, Done3;
    logic [7:0]  Xout1, Xout3;
    logic [6:0]  Yout1, Yout3;
    logic [2:0]  MemSel1, MemSel3;
    logic [11:0] Address1, Address3;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    int w1_addr[$], w1_data[$], w1_cyc[$], r1_x[$], r1_y[$], r1_cyc[$];
    int w3_addr[$], w3_data[$], w3_cyc[$], r3_x[$], r3_y[$], r3_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    capture_sprite_bg #(.READ_LATENCY(1)) u_dut1 (
        .Clock(clk), .Resetn(Resetn), .Enable(en1), .Xin(Xin), .Yin(Yin),
        .Width(Width), .Height(Height), .Slot(Slot), .Sel(Sel), .FbData(FbData1),
        .FbRead(FbRead1), .Xout(Xout1), .Yout(Yout1), .MemSel(MemSel1),
        .Address(Address1), .DataOut(DataOut1), .WriteEn(WriteEn1), .Done(Done1)
    );

    capture_sprite_bg #(.READ_LATENCY(3)) u_dut3 (
        .Clock(clk), .Resetn(Resetn), .Enable(en3), .Xin(Xin), .Yin(Yin),
        .Width(Width), .Height(Height), .Slot(Slot), .Sel(Sel), .FbData(FbData3),
        .FbRead(FbRead3), .Xout(Xout3), .Yout(Yout3), .MemSel(MemSel3),
        .Address(Address3), .DataOut(DataOut3), .WriteEn(WriteEn3), .Done(Done3)
    );

    function automatic logic [8:0] fb(input logic [7:0] x, input logic [6:0] y);
        return {x[4:0], y[3:0]};
    endfunction

    // Framebuffer models: data is valid only exactly READ_LATENCY cycles after FbRead.
    logic       p1_v = 1'b0;
    logic [8:0] p1_d = '0;
    logic [2:0] p3_v = '0;
    logic [8:0] p3_d[3];
    always @(posedge clk) begin
        p1_v    <= FbRead1;
        p1_d    <= fb(Xout1, Yout1);
        p3_v    <= {p3_v[1:0], FbRead3};
        p3_d[0] <= fb(Xout3, Yout3);
        p3_d[1] <= p3_d[0];
        p3_d[2] <= p3_d[1];
    end
    assign FbData1 = p1_v ? p1_d : GARBAGE;
    assign FbData3 = p3_v[2] ? p3_d[2] : GARBAGE;

    // Transaction recorders.
    always @(negedge clk) begin
        if (WriteEn1) begin
            w1_addr.push_back(int'(Address1)); w1_data.push_back(int'(DataOut1)); w1_cyc.push_back(cyc);
        end
        if (FbRead1) begin
            r1_x.push_back(int'(Xout1)); r1_y.push_back(int'(Yout1)); r1_cyc.push_back(cyc);
        end
        if (WriteEn3) begin
            w3_addr.push_back(int'(Address3)); w3_data.push_back(int'(DataOut3)); w3_cyc.push_back(cyc);
        end
        if (FbRead3) begin
            r3_x.push_back(int'(Xout3)); r3_y.push_back(int'(Yout3)); r3_cyc.push_back(cyc);
        end
    end

    task automatic clear_q();
        w1_addr.delete(); w1_data.delete(); w1_cyc.delete();
        r1_x.delete(); r1_y.delete(); r1_cyc.delete();
        w3_addr.delete(); w3_data.delete(); w3_cyc.delete();
        r3_x.delete(); r3_y.delete(); r3_cyc.delete();
    endtask

    // Pulse Enable on the latency-1 instance; s is the cycle after the sampling edge.
    task automatic start1(input int x, input int y, input int w, input int h,
                          input int slot, output int s);
        @(negedge clk);
        Xin = 8'(x); Yin = 7'(y); Width = 5'(w); Height = 5'(h); Slot = 3'(slot);
        en1 = 1'b1;
        @(negedge clk);
        s = cyc;
        en1 = 1'b0;
    endtask

    task automatic wait_done1(input int budget, output int dc);
        dc = -1;
        for (int k = 0; k < budget; k++) begin
            if (Done1) begin
                dc = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({Done1, FbRead1, WriteEn1, DataOut1} !== 12'd0) $display("FAIL reset_outputs: got %b, want 0", {Done1, FbRead1, WriteEn1, DataOut1});
        else n_pass++;
        Resetn = 1'b1;
        #1;
        n_total++;
        if (Done1 !== 1'b0) $display("FAIL reset_start_done: got %b, want 0", Done1);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (Done1 !== 1'b1) $display("FAIL reset_idle_done: got %b, want 1", Done1);
        else n_pass++;
    endtask

    task automatic test_basic();
        int s, dc;
        clear_q();
        Sel = 3'd5;
        start1(10, 20, 2, 2, 0, s);
        Xin = 8'd99; Yin = 7'd9; Width = 5'd7;
        n_total++;
        if (MemSel1 !== 3'd5) $display("FAIL memsel_a: got %0d, want 5", MemSel1);
        else n_pass++;
        Sel = 3'd2;
        #1;
        n_total++;
        if (MemSel1 !== 3'd2) $display("FAIL memsel_b: got %0d, want 2", MemSel1);
        else n_pass++;
        wait_done1(100, dc);
        #1;
        n_total++;
        if (dc !== s + 12) $display("FAIL basic_done_cycle: got %0d, want %0d", dc, s + 12);
        else n_pass++;
        n_total++;
        if (r1_x.size() !== 4 || w1_addr.size() !== 4) $display("FAIL basic_counts: reads %0d writes %0d, want 4 4", r1_x.size(), w1_addr.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < r1_x.size() && i < w1_addr.size(); i++) begin
            n_total++;
            if (r1_x[i] !== 10 + i % 2 || r1_y[i] !== 20 + i / 2) $display("FAIL basic_read%0d: got (%0d,%0d), want (%0d,%0d)", i, r1_x[i], r1_y[i], 10 + i % 2, 20 + i / 2);
            else n_pass++;
            n_total++;
            if (w1_addr[i] !== i || w1_data[i] !== int'(fb(8'(10 + i % 2), 7'(20 + i / 2)))) $display("FAIL basic_write%0d: got addr %0d data %0h, want %0d %0h", i, w1_addr[i], w1_data[i], i, fb(8'(10 + i % 2), 7'(20 + i / 2)));
            else n_pass++;
            n_total++;
            if (w1_cyc[i] !== s + 2 + 3 * i) $display("FAIL basic_wcyc%0d: got %0d, want %0d", i, w1_cyc[i], s + 2 + 3 * i);
            else n_pass++;
        end
    endtask

    task automatic test_slot();
        int s, dc;
        clear_q();
        start1(0, 0, 4, 4, 3, s);
        wait_done1(200, dc);
        #1;
        n_total++;
        if (w1_addr.size() !== 16) $display("FAIL slot_count: got %0d, want 16", w1_addr.size());
        else n_pass++;
        for (int i = 0; i < 16 && i < w1_addr.size(); i++) begin
            n_total++;
            if (w1_addr[i] !== 48 + i || w1_data[i] !== int'(fb(8'(i % 4), 7'(i / 4)))) $display("FAIL slot_write%0d: got addr %0d data %0h, want %0d %0h", i, w1_addr[i], w1_data[i], 48 + i, fb(8'(i % 4), 7'(i / 4)));
            else n_pass++;
        end
    endtask

    task automatic test_clip();
        int s, dc;
        clear_q();
        start1(159, 119, 2, 2, 0, s);
        wait_done1(100, dc);
        #1;
        n_total++;
        if (dc !== s + 12) $display("FAIL clip_done_cycle: got %0d, want %0d", dc, s + 12);
        else n_pass++;
        n_total++;
        if (r1_x.size() !== 1 || r1_x[0] !== 159 || r1_y[0] !== 119) $display("FAIL clip_reads: got %0d reads, want one at (159,119)", r1_x.size());
        else n_pass++;
        n_total++;
        if (w1_addr.size() !== 4) $display("FAIL clip_count: got %0d, want 4", w1_addr.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < w1_addr.size(); i++) begin
            n_total++;
            if (w1_addr[i] !== i || w1_data[i] !== ((i == 0) ? int'(fb(8'd159, 7'd119)) : int'(TRANSP)) || w1_cyc[i] !== s + 2 + 3 * i)
                $display("FAIL clip_write%0d: got addr %0d data %0h cyc %0d, want %0d %0h %0d", i, w1_addr[i], w1_data[i], w1_cyc[i], i, (i == 0) ? fb(8'd159, 7'd119) : TRANSP, s + 2 + 3 * i);
            else n_pass++;
        end
    endtask

    task automatic test_zero();
        int s;
        int low = 0;
        clear_q();
        start1(5, 5, 0, 5, 0, s);
        repeat (10) begin
            if (Done1 !== 1'b1) low++;
            @(negedge clk);
        end
        #1;
        n_total++;
        if (low !== 0) $display("FAIL zero_done: got %0d cycles low, want 0", low);
        else n_pass++;
        n_total++;
        if (r1_x.size() + w1_addr.size() !== 0) $display("FAIL zero_activity: got %0d strobes, want 0", r1_x.size() + w1_addr.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s;
        int k;
        clear_q();
        start1(0, 0, 4, 4, 0, s);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (w1_addr.size() >= 2) break;
        end
        @(negedge clk);
        #1;
        n_total++;
        if (FbRead1 !== 1'b1) $display("FAIL mid_issue: got FbRead %b, want 1", FbRead1);
        else n_pass++;
        Resetn = 1'b0;
        #1;
        n_total++;
        if ({FbRead1, WriteEn1, Done1} !== 3'b000) $display("FAIL mid_reset_drop: got %b, want 000", {FbRead1, WriteEn1, Done1});
        else n_pass++;
        repeat (3) @(negedge clk);
        Resetn = 1'b1;
        #1;
        n_total++;
        if (Done1 !== 1'b0) $display("FAIL mid_start: got Done %b, want 0", Done1);
        else n_pass++;
        repeat (6) @(negedge clk);
        #1;
        n_total++;
        if (w1_addr.size() !== 2 || Done1 !== 1'b1) $display("FAIL mid_after: got %0d writes Done %b, want 2 1", w1_addr.size(), Done1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int s;
        clear_q();
        @(negedge clk);
        Xin = 8'd30; Yin = 7'd40; Width = 5'd1; Height = 5'd1; Slot = 3'd2;
        en3 = 1'b1;
        @(negedge clk);
        s = cyc;
        repeat (6) @(negedge clk);
        en3 = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_total++;
        if (w3_addr.size() !== 2 || r3_x.size() !== 2) $display("FAIL b2b_counts: got %0d writes %0d reads, want 2 2", w3_addr.size(), r3_x.size());
        else n_pass++;
        if (w3_addr.size() == 2 && r3_x.size() == 2) begin
            n_total++;
            if (w3_cyc[0] !== s + 4) $display("FAIL lat3_write_cycle: got %0d, want %0d", w3_cyc[0], s + 4);
            else n_pass++;
            n_total++;
            if (w3_addr[0] !== 2 || w3_data[0] !== int'(fb(8'd30, 7'd40))) $display("FAIL lat3_write: got addr %0d data %0h, want 2 %0h", w3_addr[0], w3_data[0], fb(8'd30, 7'd40));
            else n_pass++;
            n_total++;
            if (r3_cyc[1] !== s + 6 || w3_cyc[1] !== s + 10) $display("FAIL b2b_restart: got read %0d write %0d, want %0d %0d", r3_cyc[1], w3_cyc[1], s + 6, s + 10);
            else n_pass++;
        end
        n_total++;
        if (Done3 !== 1'b1) $display("FAIL lat3_done: got %b, want 1", Done3);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_slot();
        test_clip();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
